// File: rtl/ifmap_buffer.sv
// Ifmap packet buffer between the decompressor and the PE-array feeder.
// First-word-fall-through FIFO with per-layer receive/drain accounting.
module ifmap_buffer #(
  parameter int unsigned DATA_W       = 64,
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned AFULL_THRESH = 2
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [CNT_W-1:0]           expected_count,
  input  logic [DATA_W-1:0]          in_data,
  input  logic                       in_valid,
  output logic                       ifmap_buffer_req,
  output logic [DATA_W-1:0]          out_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH+1)-1:0] fill_level,
  output logic                       almost_full,
  output logic                       layer_done,
  output logic                       excess_err
);

  localparam int unsigned PTR_W  = $clog2(DEPTH);
  localparam int unsigned FILL_W = $clog2(DEPTH+1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [FILL_W-1:0]  fill_q;
  logic [CNT_W-1:0]   rcv_cnt_q, pop_cnt_q, expected_q;
  logic               excess_q;
  logic [DATA_W-1:0]  mem [DEPTH];
  logic               push, pop;

  // Handshake outputs derive only from registered state.
  assign ifmap_buffer_req = (state_q == RUN) && (fill_q < FILL_W'(DEPTH)) &&
                            (rcv_cnt_q < expected_q);
  assign out_valid   = (fill_q != '0);
  assign out_data    = out_valid ? mem[rd_ptr_q] : '0;
  assign fill_level  = fill_q;
  assign almost_full = (FILL_W'(DEPTH) - fill_q) <= FILL_W'(AFULL_THRESH);
  assign layer_done  = (state_q == DONE);
  assign excess_err  = excess_q;

  // A start pulse discards any coincident transfer.
  assign push = in_valid && ifmap_buffer_req && !start;
  assign pop  = out_valid && out_ready && !start;

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = (expected_count == '0) ? DONE : RUN;
    end else begin
      unique case (state_q)
        IDLE:  state_d = IDLE;
        RUN:   if (push && (rcv_cnt_q + CNT_W'(1) == expected_q)) state_d = DRAIN;
        DRAIN: if (pop_cnt_q == expected_q) state_d = DONE;
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Pointers, occupancy, layer counters and the sticky excess flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      rcv_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      expected_q <= '0;
      excess_q   <= 1'b0;
    end else if (start) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      rcv_cnt_q  <= '0;
      pop_cnt_q  <= '0;
      expected_q <= expected_count;
      excess_q   <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      if (push && !pop)      fill_q <= fill_q + FILL_W'(1);
      else if (pop && !push) fill_q <= fill_q - FILL_W'(1);
      if (push && (rcv_cnt_q != '1)) rcv_cnt_q <= rcv_cnt_q + CNT_W'(1);
      if (pop && (pop_cnt_q != '1))  pop_cnt_q <= pop_cnt_q + CNT_W'(1);
      if (in_valid && ((state_q == DRAIN) || (state_q == DONE)) &&
          (rcv_cnt_q == expected_q))
        excess_q <= 1'b1;
    end
  end

  // Storage needs no reset; out_data is masked while empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= in_data;
  end

endmodule
